// File: rtl/rv_isa_pkg.sv
// Shared RV64I encoding constants and the operation-select enumeration.
// Used by both the instruction encoder/loader and the control decoder.
package rv_isa_pkg;

  // Major opcodes of the instruction subset the core decodes
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_DWORD   = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // Abstract operation requested of the encoder
  typedef enum logic [2:0] {
    OPS_ADD  = 3'd0,
    OPS_SUB  = 3'd1,
    OPS_AND  = 3'd2,
    OPS_OR   = 3'd3,
    OPS_LD   = 3'd4,
    OPS_SD   = 3'd5,
    OPS_BEQ  = 3'd6,
    OPS_RSVD = 3'd7
  } op_sel_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty flags and a synchronous flush.
// Storage is cleared by the asynchronous reset so the head reads zero after reset.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; flush discards any same-cycle push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes abstract operation requests into RV64I words (R-type, ld, sd, beq),
// buffers them and writes them sequentially into instruction memory.
module instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int BASE_ADDR  = 0,
  parameter int MEM_WORDS  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              err,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       wr_count
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BASE_ADDR + 4 * (MEM_WORDS - 1));
  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(4);

  op_sel_e           op_s;
  logic [31:0]       enc_word_s;
  logic              legal_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       count_r;
  logic              err_r;

  assign op_s     = op_sel_e'(op_sel);
  assign in_ready = !full_s;
  assign accept_s = in_valid && in_ready;
  assign push_s   = accept_s && legal_s && !flush;
  assign pop_s    = wr_valid && wr_ready && !flush;
  assign wr_valid = !empty_s;
  assign wr_addr  = addr_r;
  assign wr_count = count_r;
  assign err      = err_r;

  // Combinational encoder; also flags reserved ops and misaligned branch offsets
  always_comb begin
    enc_word_s = 32'd0;
    legal_s    = 1'b1;
    case (op_s)
      OPS_ADD: enc_word_s = {F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OP_RTYPE};
      OPS_SUB: enc_word_s = {F7_SUB,  rs2, rs1, F3_ADD_SUB, rd, OP_RTYPE};
      OPS_AND: enc_word_s = {F7_BASE, rs2, rs1, F3_AND,     rd, OP_RTYPE};
      OPS_OR:  enc_word_s = {F7_BASE, rs2, rs1, F3_OR,      rd, OP_RTYPE};
      OPS_LD:  enc_word_s = {imm[11:0], rs1, F3_DWORD, rd, OP_LOAD};
      OPS_SD:  enc_word_s = {imm[11:5], rs2, rs1, F3_DWORD, imm[4:0], OP_STORE};
      OPS_BEQ: begin
        enc_word_s = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
        legal_s    = !imm[0];
      end
      OPS_RSVD: legal_s = 1'b0;
      default:  legal_s = 1'b0;
    endcase
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push_s),
    .push_data (enc_word_s),
    .pop       (pop_s),
    .pop_data  (wr_data),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Write address (wrapping), saturating write count and reject pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= BASE_A;
      count_r <= 16'd0;
      err_r   <= 1'b0;
    end else if (flush) begin
      addr_r  <= BASE_A;
      count_r <= 16'd0;
      err_r   <= 1'b0;
    end else begin
      err_r <= accept_s && !legal_s;
      if (pop_s) begin
        if (addr_r == LAST_A) begin
          addr_r <= BASE_A;
        end else begin
          addr_r <= addr_r + STEP_A;
        end
        if (count_r != 16'hFFFF) begin
          count_r <= count_r + 16'd1;
        end else begin
          count_r <= count_r;
        end
      end else begin
        addr_r  <= addr_r;
        count_r <= count_r;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader with a queue-based
// reference model computed from the instruction-format rules.
module tb_instr_encoder_loader;

  localparam int DEPTH     = 4;
  localparam int BASE      = 0;
  localparam int MEM_WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op_sel = 3'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [12:0] imm = 13'd0;
  logic        err;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] wr_count;

  instr_encoder_loader #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (32),
    .BASE_ADDR  (BASE),
    .MEM_WORDS  (MEM_WORDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sel   (op_sel),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .err      (err),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // reference model state
  logic [31:0] q[$];
  int          addr_idx = 0;
  int          wcount   = 0;
  bit          err_exp  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_encode(input int op, input int d, input int s1,
                                             input int s2, input int im);
    int unsigned w;
    int unsigned base;
    base = (s2 << 20) + (s1 << 15);
    case (op)
      0: w = base + (0 << 12) + (d << 7) + 51;
      1: w = (32 << 25) + base + (0 << 12) + (d << 7) + 51;
      2: w = base + (7 << 12) + (d << 7) + 51;
      3: w = base + (6 << 12) + (d << 7) + 51;
      4: w = ((im & 'hFFF) << 20) + (s1 << 15) + (3 << 12) + (d << 7) + 3;
      5: w = (((im >> 5) & 'h7F) << 25) + base + (3 << 12) + ((im & 'h1F) << 7) + 35;
      6: w = (((im >> 12) & 1) << 31) + (((im >> 5) & 'h3F) << 25) + base
             + (((im >> 1) & 'hF) << 8) + (((im >> 11) & 1) << 7) + 99;
      default: w = 0;
    endcase
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    addr_idx = 0;
    wcount   = 0;
    err_exp  = 1'b0;
  endtask

  task automatic check_outputs();
    check_val("in_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
    check_val("wr_valid", {31'd0, wr_valid}, {31'd0, q.size() > 0});
    check_val("wr_addr", wr_addr, BASE + 4 * addr_idx);
    check_val("wr_count", {16'd0, wr_count}, wcount);
    check_val("err", {31'd0, err}, {31'd0, err_exp});
    if (q.size() > 0) check_val("wr_data", wr_data, q[0]);
  endtask

  // Drive one cycle of inputs (called just after a negedge), advance the
  // model over the next posedge, then check at the following negedge.
  task automatic step(input bit iv, input int op, input int d, input int s1, input int s2,
                      input int im, input bit wrdy, input bit fl);
    int occ;
    bit acc, pp, legal;
    in_valid = iv; op_sel = op[2:0]; rd = d[4:0]; rs1 = s1[4:0]; rs2 = s2[4:0];
    imm = im[12:0]; wr_ready = wrdy; flush = fl;
    occ   = q.size();
    acc   = iv && (occ < DEPTH);
    pp    = (occ > 0) && wrdy;
    legal = (op != 7) && !((op == 6) && ((im & 1) == 1));
    if (fl) begin
      model_reset();
    end else begin
      if (pp) begin
        void'(q.pop_front());
        addr_idx = (addr_idx + 1) % MEM_WORDS;
        if (wcount < 65535) wcount++;
      end
      if (acc && legal) q.push_back(ref_encode(op, d, s1, s2, im & 'h1FFF));
      err_exp = acc && !legal;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit wrdy);
    step(1'b0, 0, 0, 0, 0, 0, wrdy, 1'b0);
  endtask

  logic [31:0] held;
  logic [15:0] cnt_save;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check_val("rst_wr_addr", wr_addr, BASE);
    check_val("rst_wr_data", wr_data, 32'd0);
    check_val("rst_err", {31'd0, err}, 32'd0);
    check_val("rst_wr_count", {16'd0, wr_count}, 32'd0);
    rst_n = 1'b1;
    model_reset();

    // single ADD
    step(1'b1, 0, 3, 1, 2, 0, 1'b1, 1'b0);
    check_val("add_data", wr_data, 32'h002081B3);
    check_val("add_addr", wr_addr, 32'd0);
    idle(1'b1);
    check_val("add_addr_next", wr_addr, 32'd4);
    check_val("add_count", {16'd0, wr_count}, 32'd1);

    // back-to-back from a fresh address
    step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    step(1'b1, 1, 3, 1, 2, 0, 1'b1, 1'b0);
    check_val("sub_data", wr_data, 32'h402081B3);
    step(1'b1, 4, 5, 10, 0, 8, 1'b1, 1'b0);
    check_val("ld_data", wr_data, 32'h00853283);
    check_val("ld_addr", wr_addr, 32'd4);
    step(1'b1, 5, 0, 2, 6, 16, 1'b1, 1'b0);
    check_val("sd_data", wr_data, 32'h00613823);
    step(1'b1, 6, 0, 1, 2, 8, 1'b1, 1'b0);
    check_val("beq_data", wr_data, 32'h00208463);
    check_val("beq_addr", wr_addr, 32'd12);
    idle(1'b1);
    check_val("wrap_addr", wr_addr, 32'd0);

    // stall: 5 offers with wr_ready low, then drain
    step(1'b1, 2, 7, 8, 9, 0, 1'b0, 1'b0);
    held = wr_data;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3, i + 1, i + 2, i + 3, 0, 1'b0, 1'b0);
      check_val("stall_hold", wr_data, held);
    end
    check_val("stall_full", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // rejected requests
    cnt_save = wr_count;
    step(1'b1, 7, 1, 1, 1, 0, 1'b1, 1'b0);
    check_val("err_rsvd", {31'd0, err}, 32'd1);
    step(1'b1, 6, 0, 1, 2, 3, 1'b1, 1'b0);
    check_val("err_beq", {31'd0, err}, 32'd1);
    check_val("err_nopush", {31'd0, wr_valid}, 32'd0);
    idle(1'b1);
    check_val("err_count", {16'd0, wr_count}, {16'd0, cnt_save});

    // flush with 3 words queued
    for (int i = 0; i < 3; i++) step(1'b1, 0, i, i, i, 0, 1'b0, 1'b0);
    step(1'b1, 1, 1, 1, 1, 0, 1'b1, 1'b1);
    check_val("flush_valid", {31'd0, wr_valid}, 32'd0);
    check_val("flush_addr", wr_addr, BASE);
    check_val("flush_count", {16'd0, wr_count}, 32'd0);

    // asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) step(1'b1, 2, i, i, i, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    wr_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", {31'd0, wr_valid}, 32'd0);
    check_val("arst_addr", wr_addr, BASE);
    check_val("arst_count", {16'd0, wr_count}, 32'd0);
    check_val("arst_ready", {31'd0, in_ready}, 32'd1);
    check_val("arst_data", wr_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 8191),
           $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder-side counterpart of the main control decoder. It turns abstract operation requests into RV64I instruction words for the opcode set the core decodes: R-format, ld, sd, beq.
- Encoded words are buffered in a small FIFO and written sequentially into instruction memory through a valid/ready write port.
- Used for program loading and self-test injection ahead of the core fetch path.

Parameters:
- FIFO_DEPTH, 4, encoded-word buffer depth; power of 2, at least 2.
- ADDR_W, 32, instruction memory byte-address width.
- BASE_ADDR, 0, first write address after reset or flush.
- MEM_WORDS, 256, instruction memory size in words; the address wraps to BASE_ADDR after MEM_WORDS writes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO, address counter and count.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- op_sel  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 LD, 5 SD, 6 BEQ, 7 reserved.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- imm  in  13  signed immediate; LD/SD use imm[11:0]; BEQ uses a 13-bit byte offset.
- err  out  1  one-cycle pulse on a rejected request.
- wr_valid  out  1  instruction word available to write.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  ADDR_W  byte address of the current write.
- wr_data  out  32  encoded instruction.
- wr_count  out  16  total words written since reset/flush; saturates at 0xFFFF.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, in_ready=1, wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, err=0, wr_count=0.
- Accept: in_ready = !full. The full flag is evaluated before any same-cycle pop, so in_ready stays 0 when full even if a write completes that cycle.
- Encoding is combinational from the request fields. An accepted legal request pushes its word; wr_valid rises the next cycle. Minimum latency from accept to write is 1 cycle.
- R-format (opcode 0110011), field order funct7|rs2|rs1|funct3|rd|opcode:
  - ADD: funct7 0000000, funct3 000.
  - SUB: funct7 0100000, funct3 000.
  - AND: funct7 0000000, funct3 111.
  - OR: funct7 0000000, funct3 110.
- LD (opcode 0000011): imm[11:0]|rs1|011|rd|opcode.
- SD (opcode 0100011): imm[11:5]|rs2|rs1|011|imm[4:0]|opcode.
- BEQ (opcode 1100011): imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|opcode.
- Rejected requests: op_sel=7, or BEQ with imm[0]=1.
  - The request is still handshaked (consumed) and nothing is pushed.
  - err pulses high the cycle after acceptance.
- Write port:
  - wr_valid = !empty; wr_data = FIFO head; wr_addr = current address.
  - wr_data and wr_addr stay stable while wr_valid && !wr_ready.
  - On wr_valid && wr_ready: pop, wr_addr += 4, wr_count++.
  - Wrap: after the write at BASE_ADDR+4*(MEM_WORDS-1), wr_addr returns to BASE_ADDR.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, ordering preserved.
- Empty FIFO with push: the word is not bypassed and appears on wr_valid the next cycle.
- flush:
  - Next cycle: FIFO empty, wr_addr=BASE_ADDR, wr_count=0, err=0.
  - Any in-flight push or pop that same cycle is discarded.
  - flush dominates all other events.
- Reset mid-transfer: outputs take their reset values immediately, independent of clk. Memory must ignore wr_valid=0.

Decomposition:
- Shared package rv_isa_pkg holds:
  - opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH.
  - funct3/funct7 constants.
  - op_sel enumeration.
  - This package is also used by the control decoder.
- Sub-module sync_fifo (width 32, depth FIFO_DEPTH, with full/empty/flush). The encoder and address logic stay at top level.

Test Plan:
- After reset, ADD rd=3 rs1=1 rs2=2 with wr_ready=1 -> next cycle wr_valid=1, wr_data=0x002081B3, wr_addr=0; then wr_addr=4, wr_count=1.
- SUB, LD x5,8(x10), SD x6,16(x2), BEQ x1,x2,+8 back-to-back -> wr_data 0x402081B3, 0x00853283, 0x00613823, 0x00208463 at addresses 0, 4, 8, 12.
- wr_ready=0 while 5 requests are offered -> in_ready falls after 4 accepts. The first word stays stable. After wr_ready=1, all 4 words drain in order, one per cycle.
- op_sel=7, then BEQ with imm=3 -> err pulses twice, nothing is pushed, wr_count unchanged.
- MEM_WORDS=4, 5 writes -> addresses 0, 4, 8, 12, 0.
- flush with 3 words queued, and rst_n low mid-transfer -> FIFO empty, wr_addr=BASE_ADDR, wr_count=0; reset drives wr_valid=0 asynchronously.
